alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single execute-stage ALU between two requesters: requester 0 is the pipeline EX stage, requester 1 is the branch/address-compare path.
- Arbitrates round-robin with a valid/ready handshake and drives the ALU-op/funct/operand inputs of the existing ALU control decoder plus the ALU.
- Captures the ALU result and returns it on a per-requester response handshake.
- Non-pipelined: one operation in flight.

Parameters:
- DATA_W, 32, operand/result width.
- CNT_W, 16, width of issued-operation counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_aluop  in  3  ALUop encoding (000 add, 001 sub, 010 add, 011 sub, 100 R-type)
- req0_funct  in  6  funct field (used when aluop=100)
- req0_a, req0_b  in  DATA_W  operands
- req1_valid / req1_ready / req1_aluop / req1_funct / req1_a / req1_b  same as requester 0
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes result
- rsp1_valid  out  1  result for requester 1 available
- rsp1_ready  in  1  requester 1 takes result
- rsp_result  out  DATA_W  result (shared bus, owner indicated by rspX_valid)
- rsp_zero  out  1  result==0 (branch compare)
- rsp_err  out  1  illegal opcode flag (see Optional Feature)
- alu_op  out  3  to ALU control decoder
- alu_funct  out  6  to ALU control decoder
- alu_a, alu_b  out  DATA_W  to ALU
- alu_result  in  DATA_W  from ALU, combinational, same cycle
- op_count  out  CNT_W  operations issued since reset

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - grant = round-robin over req0_valid/req1_valid. If both are valid, grant goes to the requester not served last; last_grant resets to 1, so req0 wins the first tie.
  - reqX_ready = (state==IDLE) & grant==X & reqX_valid. Ready may depend combinationally on valid; valid must not depend on ready.
  - On handshake: register aluop, funct, a, b and owner; update last_grant; go to ISSUE.
- ISSUE:
  - alu_* driven from the registered values, exactly one cycle.
  - At the clock edge: capture alu_result into rsp_result, set rsp_zero=(alu_result==0), op_count += 1 (wraps modulo 2^CNT_W), go to RESP.
- RESP:
  - rsp<owner>_valid=1 and the other rsp valid=0; payload held stable.
  - rsp<owner>_valid & rsp<owner>_ready -> IDLE. A new request may be accepted no earlier than the following cycle.
- Latency: handshake at cycle N, response valid from cycle N+2. Max throughput is one op per 3 cycles.
- All reqX_ready are 0 outside IDLE. Requesters hold valid and payload stable until ready.
- alu_* outputs are 0 when not in ISSUE.
- Response backpressure: RESP persists indefinitely; no requests are accepted meanwhile.
- Reset (any state, including mid-ISSUE/RESP): state=IDLE, last_grant=1, all ready/rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, alu_*=0, op_count=0. An in-flight op is dropped with no response.
- Simultaneous rsp handshake and new valid in the same cycle: the new request waits for IDLE (next cycle).

Optional Feature:
- Macro ALU_ARB_ILLEGAL_CHECK_EN.
- Defined: an op is legal if aluop is in 000..011, or aluop=100 with funct in {100000, 100010, 100110}.
  - An illegal op is accepted normally but skips ISSUE: IDLE -> RESP directly (response at N+1).
  - Illegal response: rsp_err=1, rsp_result=0, rsp_zero=0, op_count unchanged, ALU not driven.
- Undefined: every op is issued to the ALU, rsp_err is tied to 0, latency is always N+2.

Decomposition:
- Package alu_arb_pkg holds:
  - ALUOP_* constants (LWSW=000, BEQ=001, ADDI=010, SUBI=011, RTYPE=100).
  - FUNCT_ADD=100000, FUNCT_SUB=100010, FUNCT_XOR=100110.
  - FSM state enum.
- One sub-module: rr_arb2, the two-requester round-robin grant with last_grant register, update-enable input and synchronous reset.

Test Plan:
- Single op: req0 aluop=100 funct=100000 a=5 b=7, rsp0_ready=1 -> handshake at N; rsp0_valid at N+2 with result=12, zero=0; op_count=1.
- Tie: req0 and req1 both valid every cycle with sub 9-9 and add 1+2 -> grants strictly alternate 0,1,0,1; req1 responses show result 3, zero=0; req0 responses show zero=1.
- Backpressure: hold rsp1_ready=0 for 10 cycles -> rsp1_valid stays high, result stable, both req ready=0 throughout; release -> IDLE next cycle.
- Reset mid-op: assert reset in ISSUE -> next cycle all outputs 0, no rsp_valid ever appears for the dropped op, op_count=0; req0 wins the first following tie.
- Counter wrap: CNT_W=4, issue 17 ops -> op_count=1.
- Illegal op (with ALU_ARB_ILLEGAL_CHECK_EN): aluop=100 funct=000000 -> rsp_valid at N+1, rsp_err=1, result=0, op_count unchanged. Without the macro: issued, response at N+2, rsp_err=0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: ALU-op / funct encodings,
// the arbiter FSM state type and the op-legality helper used when
// ALU_ARB_ILLEGAL_CHECK_EN is defined.
package alu_arb_pkg;

  localparam logic [2:0] ALUOP_LWSW  = 3'b000;
  localparam logic [2:0] ALUOP_BEQ   = 3'b001;
  localparam logic [2:0] ALUOP_ADDI  = 3'b010;
  localparam logic [2:0] ALUOP_SUBI  = 3'b011;
  localparam logic [2:0] ALUOP_RTYPE = 3'b100;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } alu_arb_state_e;

  // Legal ops: the four fixed add/sub encodings, or R-type with add/sub/xor.
  function automatic logic op_is_legal(input logic [2:0] aluop, input logic [5:0] funct);
    logic legal;
    legal = 1'b0;
    case (aluop)
      ALUOP_LWSW, ALUOP_BEQ, ALUOP_ADDI, ALUOP_SUBI: legal = 1'b1;
      ALUOP_RTYPE: legal = (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_XOR);
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-requester round-robin grant. On a tie the requester not served
// last wins; last grant resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       grant_o
);

  logic last_q;

  // Grant selection: tie goes to the other side of last_q; otherwise
  // the only requester (index 0 when nobody requests).
  always_comb begin
    if (req_i == 2'b11) grant_o = ~last_q;
    else                grant_o = req_i[1];
  end

  // Remember who was served when a handshake happens.
  always_ff @(posedge clk) begin
    if (reset)         last_q <= 1'b1;
    else if (update_i) last_q <= grant_o;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one execute-stage ALU between the EX stage (requester 0) and the
// branch/address-compare path (requester 1). One op in flight:
// IDLE -> ISSUE (ALU driven one cycle) -> RESP (held until taken).
// Optional macro ALU_ARB_ILLEGAL_CHECK_EN: illegal ops bypass the ALU and
// answer from RESP with rsp_err=1 one cycle after acceptance.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both 1. Ready may depend on valid; valid never depends on
// ready, and a requester holds valid and payload stable until ready.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_aluop,
  input  logic [5:0]        req0_funct,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_aluop,
  input  logic [5:0]        req1_funct,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [2:0]        alu_op,
  output logic [5:0]        alu_funct,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [CNT_W-1:0]  op_count,
  output alu_arb_state_e    dbg_state_o
);

  alu_arb_state_e    state_q, state_d;
  logic              owner_q;
  logic [2:0]        op_q;
  logic [5:0]        funct_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic              err_q;
  logic [CNT_W-1:0]  count_q;

  logic              grant;
  logic              req_hs;
  logic              rsp_hs;
  logic              sel_legal;
  logic [2:0]        sel_op;
  logic [5:0]        sel_funct;
  logic [DATA_W-1:0] sel_a, sel_b;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .req_i    ({req1_valid, req0_valid}),
    .update_i (req_hs),
    .grant_o  (grant)
  );

  assign req0_ready = (state_q == ST_IDLE) && !grant && req0_valid;
  assign req1_ready = (state_q == ST_IDLE) &&  grant && req1_valid;
  assign req_hs     = req0_ready | req1_ready;
  assign rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  assign sel_op    = grant ? req1_aluop : req0_aluop;
  assign sel_funct = grant ? req1_funct : req0_funct;
  assign sel_a     = grant ? req1_a     : req0_a;
  assign sel_b     = grant ? req1_b     : req0_b;

`ifdef ALU_ARB_ILLEGAL_CHECK_EN
  assign sel_legal = op_is_legal(sel_op, sel_funct);
`else
  assign sel_legal = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: illegal ops skip ISSUE; RESP waits for the owner to take it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_hs) state_d = sel_legal ? ST_ISSUE : ST_RESP;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  if (rsp_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: ALU inputs only during ISSUE, response valid only to the owner in RESP.
  always_comb begin
    alu_op     = '0;
    alu_funct  = '0;
    alu_a      = '0;
    alu_b      = '0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    if (state_q == ST_ISSUE) begin
      alu_op    = op_q;
      alu_funct = funct_q;
      alu_a     = a_q;
      alu_b     = b_q;
    end
    if (state_q == ST_RESP) begin
      rsp0_valid = !owner_q;
      rsp1_valid =  owner_q;
    end
  end

  // Datapath: capture the request on acceptance, the ALU result at the end of ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= 1'b0;
      op_q     <= '0;
      funct_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else if (req_hs) begin
      owner_q <= grant;
      op_q    <= sel_op;
      funct_q <= sel_funct;
      a_q     <= sel_a;
      b_q     <= sel_b;
      err_q   <= !sel_legal;
      if (!sel_legal) begin
        result_q <= '0;
        zero_q   <= 1'b0;
      end
    end else if (state_q == ST_ISSUE) begin
      result_q <= alu_result;
      zero_q   <= (alu_result == '0);
      count_q  <= count_q + CNT_W'(1);
    end
  end

  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rsp_err     = err_q;
  assign op_count    = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU model, per-requester driver task,
// scoreboard queue filled at request acceptance and drained at response.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int EXP_W  = DATA_W + 3;   // {owner, err, zero, result}

  logic              clk;
  logic              reset;
  logic              req0_valid, req0_ready;
  logic [2:0]        req0_aluop;
  logic [5:0]        req0_funct;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic              req1_valid, req1_ready;
  logic [2:0]        req1_aluop;
  logic [5:0]        req1_funct;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic              rsp0_valid, rsp0_ready;
  logic              rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero, rsp_err;
  logic [2:0]        alu_op;
  logic [5:0]        alu_funct;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [CNT_W-1:0]  op_count;
  alu_arb_state_e    dbg_state;

  logic [EXP_W-1:0]  exp_q[$];
  int                grant_log[$];
  int                model_cnt;
  int                n_checks;
  int                n_errors;

  alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
    .req0_funct(req0_funct), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
    .req1_funct(req1_funct), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .op_count(op_count), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- reference models ----------------
  function automatic logic [DATA_W-1:0] alu_model(input logic [2:0] op, input logic [5:0] f,
                                                  input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    case (op)
      3'b000, 3'b010: return a + b;
      3'b001, 3'b011: return a - b;
      3'b100: begin
        case (f)
          6'b100000: return a + b;
          6'b100010: return a - b;
          6'b100110: return a ^ b;
          default:   return a | b;
        endcase
      end
      default: return a | b;
    endcase
  endfunction

  function automatic logic model_legal(input logic [2:0] op, input logic [5:0] f);
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    if (op <= 3'b011) return 1'b1;
    if (op == 3'b100) return (f == 6'h20) || (f == 6'h22) || (f == 6'h26);
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [EXP_W-1:0] make_exp(input int who, input logic [2:0] op, input logic [5:0] f,
                                                input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    if (!model_legal(op, f)) return {who[0], 1'b1, 1'b0, {DATA_W{1'b0}}};
    r = alu_model(op, f, a, b);
    return {who[0], 1'b0, (r == '0), r};
  endfunction

  always_comb alu_result = alu_model(alu_op, alu_funct, alu_a, alu_b);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic pop_and_check(input int who);
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      check("rsp_unexpected", 64'(who + 1), 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("rsp_owner",  64'(who),        64'(e[EXP_W-1]));
      check("rsp_err",    64'(rsp_err),    64'(e[DATA_W+1]));
      check("rsp_zero",   64'(rsp_zero),   64'(e[DATA_W]));
      check("rsp_result", 64'(rsp_result), 64'(e[DATA_W-1:0]));
    end
  endtask

  // Scoreboard side: compare every taken response against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp0_valid && rsp1_valid) check("rsp_both_valid", 64'd1, 64'd0);
      if (rsp0_valid && rsp0_ready) pop_and_check(0);
      if (rsp1_valid && rsp1_ready) pop_and_check(1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int who, input logic [2:0] op, input logic [5:0] f,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    bit got;
    got = 1'b0;
    if (who == 0) begin
      req0_valid = 1'b1; req0_aluop = op; req0_funct = f; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_aluop = op; req1_funct = f; req1_a = a; req1_b = b;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((who == 0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("req_accept_timeout", 64'd0, 64'd1);
    end else begin
      exp_q.push_back(make_exp(who, op, f, a, b));
      grant_log.push_back(who);
      if (model_legal(op, f)) model_cnt++;
    end
    @(posedge clk);
    #1;
    if (who == 0) req0_valid = 1'b0;
    else          req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Reset from any point; checks every output one cycle after reset is sampled.
  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_q.delete();
    grant_log.delete();
    model_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_state",      64'(dbg_state),  64'(ST_IDLE));
    check("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    check("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    check("rst_result",     64'(rsp_result), 64'd0);
    check("rst_zero",       64'(rsp_zero),   64'd0);
    check("rst_err",        64'(rsp_err),    64'd0);
    check("rst_alu_op",     64'(alu_op),     64'd0);
    check("rst_alu_a",      64'(alu_a),      64'd0);
    check("rst_alu_b",      64'(alu_b),      64'd0);
    check("rst_op_count",   64'(op_count),   64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] op;
    logic [5:0] f;
    logic [5:0] rfuncts [3];
    int         who;
    n_checks = 0;
    n_errors = 0;
    model_cnt = 0;
    reset = 1'b1;
    req0_valid = 1'b0; req0_aluop = '0; req0_funct = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_aluop = '0; req1_funct = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    rfuncts[0] = 6'b100000; rfuncts[1] = 6'b100010; rfuncts[2] = 6'b100110;
    repeat (2) @(posedge clk);
    do_reset();

    // Single R-type add 5+7: ISSUE at N+1, response at N+2.
    send(0, 3'b100, 6'b100000, 32'd5, 32'd7);
    @(negedge clk);
    check("single_issue_state", 64'(dbg_state), 64'(ST_ISSUE));
    check("single_alu_op",      64'(alu_op),     64'h4);
    check("single_alu_funct",   64'(alu_funct),  64'h20);
    check("single_alu_a",       64'(alu_a),      64'd5);
    check("single_alu_b",       64'(alu_b),      64'd7);
    check("single_early_rsp",   64'(rsp0_valid), 64'd0);
    @(negedge clk);
    check("single_rsp_valid",   64'(rsp0_valid), 64'd1);
    check("single_result",      64'(rsp_result), 64'd12);
    check("single_zero",        64'(rsp_zero),   64'd0);
    check("single_alu_idle",    64'(alu_a),      64'd0);
    check("single_op_count",    64'(op_count),   64'd1);
    wait_drain();

    // Reset while the op is in ISSUE: dropped, no response afterwards.
    send(0, 3'b000, 6'd0, 32'd5, 32'd7);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dropped_rsp0", 64'(rsp0_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Tie: both requesters always valid -> grants strictly alternate, req0 first.
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 3'b001, 6'd0, 32'd9, 32'd9);
      end
      begin
        for (int i = 0; i < 4; i++) send(1, 3'b000, 6'd0, 32'd1, 32'd2);
      end
    join
    wait_drain();
    check("tie_grant_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < grant_log.size(); i++) check("tie_grant_order", 64'(grant_log[i]), 64'(i % 2));

    // Backpressure on requester 1 while requester 0 waits.
    rsp1_ready = 1'b0;
    send(1, 3'b010, 6'd0, 32'd1, 32'd2);
    fork
      send(0, 3'b100, 6'b100010, 32'd10, 32'd3);
      begin
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("bp_rsp1_valid",  64'(rsp1_valid), 64'd1);
          check("bp_result",      64'(rsp_result), 64'd3);
          check("bp_req0_ready",  64'(req0_ready), 64'd0);
          check("bp_req1_ready",  64'(req1_ready), 64'd0);
          check("bp_state",       64'(dbg_state),  64'(ST_RESP));
        end
        @(posedge clk);
        #1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(rsp1_valid), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_back_idle",   64'(dbg_state),  64'(ST_IDLE));
        check("bp_req0_accept", 64'(req0_ready), 64'd1);
      end
    join
    wait_drain();

    // Counter wrap: 17 legal ops on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      who = int'($urandom_range(0, 1));
      op  = 3'($urandom_range(0, 4));
      f   = rfuncts[$urandom_range(0, 2)];
      send(who, op, f, 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)));
    end
    wait_drain();
    check("wrap_model_cnt", 64'(model_cnt), 64'd17);
    check("wrap_op_count",  64'(op_count),  64'd1);

    // Unsupported R-type funct.
    send(0, 3'b100, 6'b000000, 32'd3, 32'd4);
    @(negedge clk);
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    check("illegal_rsp_n1",  64'(rsp0_valid), 64'd1);
    check("illegal_err",     64'(rsp_err),    64'd1);
    check("illegal_result",  64'(rsp_result), 64'd0);
    check("illegal_zero",    64'(rsp_zero),   64'd0);
    check("illegal_alu_op",  64'(alu_op),     64'd0);
`else
    check("funct0_no_rsp_n1", 64'(rsp0_valid), 64'd0);
    check("funct0_alu_op",    64'(alu_op),     64'h4);
    @(negedge clk);
    check("funct0_rsp_n2",    64'(rsp0_valid), 64'd1);
    check("funct0_err",       64'(rsp_err),    64'd0);
`endif
    wait_drain();
    check("final_op_count", 64'(op_count), 64'(model_cnt % 16));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
